// File: rtl/tile_inverse_transform_unit.sv
// ----------------------------------------------------------------------------
// tile_inverse_transform_unit
//
// Winograd F(4x4,3x3) output transform: Y = A^T * M * A, where M is a 6x6
// element-wise-product tile and Y is the 4x4 spatial output tile. The math is
// done in two passes through one shared A^T kernel per pass:
//   STAGE1 (6 cycles): T[:, j] = A^T * M[:, j]  (one column of M per cycle)
//   STAGE2 (4 cycles): Y[r, :] = A^T * T[r, :]  (one row of T per cycle)
// followed by a single OUTPUT cycle that publishes Y on tile_out.
// All coefficients (1, 2, 4, 8) are realised as shifts and adds.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   start          request, sampled only while idle
//   tile_in        6x6 signed M tile (DATA_W per element), latched on accept
//   tile_out       4x4 signed Y tile (OUT_W per element), registered
//   transform_done one-cycle pulse coincident with the tile_out update
//   busy           high from the cycle after accept until transform_done
// ----------------------------------------------------------------------------

// One application of A^T to a 6-element vector. Inputs are sign-extended to
// OUT_W first, so the sum cannot wrap as long as OUT_W >= IN_W + 5
// (worst-case row gain is 19).
module itu_at_kernel #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 21
) (
    input  logic [0:5][IN_W-1:0]  x,
    output logic [0:3][OUT_W-1:0] y
);
    logic signed [OUT_W-1:0] e [0:5];

    for (genvar k = 0; k < 6; k++) begin : g_ext
        assign e[k] = OUT_W'($signed(x[k]));
    end

    // Shared pair terms: rows 1 and 3 use the differences, row 2 the sums.
    logic signed [OUT_W-1:0] d12, d34, s12, s34;
    assign d12 = e[1] - e[2];
    assign d34 = e[3] - e[4];
    assign s12 = e[1] + e[2];
    assign s34 = e[3] + e[4];

    assign y[0] = e[0] + s12 + s34;
    assign y[1] = d12 + (d34 <<< 1);
    assign y[2] = s12 + (s34 <<< 2);
    assign y[3] = d12 + (d34 <<< 3) + e[5];
endmodule

module tile_inverse_transform_unit #(
    parameter int DATA_W = 16,
    parameter int MID_W  = DATA_W + 5,
    parameter int OUT_W  = DATA_W + 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [0:5][0:5][DATA_W-1:0]  tile_in,
    output logic [0:3][0:3][OUT_W-1:0]   tile_out,
    output logic                         transform_done,
    output logic                         busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STAGE1 = 2'd1;
    localparam logic [1:0] S_STAGE2 = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]                      state;
    logic [2:0]                      cnt;
    logic [0:5][0:5][DATA_W-1:0]     m_reg;
    logic [0:3][0:5][MID_W-1:0]      t_reg;
    logic [0:3][0:3][OUT_W-1:0]      y_reg;

    // Stage-1 operand: column cnt of M. Stage-2 operand: row cnt of T.
    logic [0:5][DATA_W-1:0] col_vec;
    logic [0:5][MID_W-1:0]  row_vec;
    logic [0:3][MID_W-1:0]  col_res;
    logic [0:3][OUT_W-1:0]  row_res;

    always_comb begin
        col_vec = '0;
        row_vec = '0;
        for (int k = 0; k < 6; k++) begin
            col_vec[k] = m_reg[k][cnt];
            row_vec[k] = t_reg[cnt[1:0]][k];
        end
    end

    itu_at_kernel #(.IN_W(DATA_W), .OUT_W(MID_W)) u_stage1 (
        .x (col_vec),
        .y (col_res)
    );

    itu_at_kernel #(.IN_W(MID_W), .OUT_W(OUT_W)) u_stage2 (
        .x (row_vec),
        .y (row_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            m_reg          <= '0;
            t_reg          <= '0;
            y_reg          <= '0;
            tile_out       <= '0;
            transform_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            transform_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= tile_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_STAGE1;
                    end
                end
                S_STAGE1: begin
                    for (int i = 0; i < 4; i++) begin
                        t_reg[i][cnt] <= col_res[i];
                    end
                    if (cnt == 3'd5) begin
                        cnt   <= '0;
                        state <= S_STAGE2;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_STAGE2: begin
                    y_reg[cnt[1:0]] <= row_res;
                    if (cnt == 3'd3) begin
                        cnt   <= '0;
                        state <= S_OUTPUT;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    // S_OUTPUT: publish and return; a start seen here is
                    // dropped, the next one is taken in IDLE.
                    tile_out       <= y_reg;
                    transform_done <= 1'b1;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end
endmodule
